alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Command-driven sequencer for the 32-bit ALU/accumulator datapath: operand register R1, accumulator ACC, and a 4-way op mux {-R1, R1&ACC, -ACC, ACC+R1}.
- Accepts one command per handshake: op, operand, repeat count.
- Loads R1, strobes the ACC write for the requested number of cycles, then returns the final ACC value with a done pulse.
- Replaces the free-running op counter with explicit, software-controlled sequencing.

Parameters:
DATA_W, 32, datapath width (operand, ACC, result).
CNT_W, 8, width of the repeat count; max repeats 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command.
cmd_op  input  2  op code: 00 -R1, 01 R1&ACC, 10 -ACC, 11 ACC+R1.
cmd_data  input  DATA_W  operand destined for R1.
cmd_count  input  CNT_W  number of ACC write cycles.
abort  input  1  synchronous cancel of the current command.
acc_q  input  DATA_W  current ACC value from the datapath.
r1_load  output  1  R1 write strobe.
r1_data  output  DATA_W  R1 write data.
op_sel  output  2  datapath mux select.
acc_we  output  1  ACC write enable.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle completion pulse.
result  output  DATA_W  ACC snapshot, valid from done onward.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - cmd_ready=1.
  - r1_load=0, acc_we=0, busy=0, done=0.
  - op_sel=00, r1_data=0, result=0.
- States: IDLE, LOAD, EXEC, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op, data and count; go to LOAD.
  - cmd_ready is 0 in every other state.
- LOAD (1 cycle):
  - r1_load=1, r1_data=latched data.
  - Count==0: go to DONE. Otherwise load the remaining-count register with count and go to EXEC.
- EXEC:
  - acc_we=1 and op_sel=latched op every cycle.
  - Decrement remaining each cycle; go to DONE when remaining==1.
  - Exactly `count` ACC writes occur.
- DONE (1 cycle):
  - done=1; result<=acc_q, which reflects the last write; go to IDLE.
  - result holds until the next DONE or reset.
- Latency, with accept at edge 0:
  - LOAD at cycle 1.
  - EXEC at cycles 2..count+1.
  - done at cycle count+2; for count 0, done at cycle 2.
  - The next command can be accepted in the cycle after done.
- abort:
  - In LOAD or EXEC: go to IDLE at the next edge, no done, result unchanged; ACC keeps any writes already made.
  - Ignored in IDLE and DONE.
  - abort wins over the EXEC-to-DONE transition in the same cycle.
- op_sel outside EXEC: holds the last latched op (00 after reset).
- acc_we is never asserted outside EXEC.
- Datapath arithmetic is two's complement, wrap mod 2^DATA_W; the controller performs none of it.
- Reset mid-command: immediate return to the reset values; the command is lost.

Optional Feature:
Macro ALU_SEQ_ROTATE_EN.
- Defined: in EXEC, op_sel starts at the latched op and increments mod 4 on each write cycle (00→01→10→11→00), emulating the original free-running op counter.
- Undefined: op_sel is constant at the latched op for the whole command.

Decomposition:
Package alu_seq_pkg:
- state enum (IDLE, LOAD, EXEC, DONE).
- op-code localparams OP_NEG_R1, OP_AND, OP_NEG_ACC, OP_ADD.
- DATA_W/CNT_W defaults.

One sub-module, alu_seq_cnt:
- loadable down-counter, CNT_W wide.
- outputs last (remaining==1).
- includes the op rotation increment when ALU_SEQ_ROTATE_EN is defined.

The FSM and output registers stay in the top level.

Test Plan:
- Reset state: hold rst_n=0 mid-EXEC → all outputs immediately at reset values; after release, cmd_ready=1.
- Single add: ACC=5, cmd op=11, data=7, count=3 → r1_load at cycle 1; acc_we for 3 cycles; done at cycle 5 with result=26.
- Zero count: op=01, data=0xFFFF0000, count=0 → r1_load once, no acc_we, done at cycle 2, result=previous ACC.
- Negate with wrap: ACC=0x80000000, op=10, count=1 → result=0x80000000. Back-to-back command held valid is accepted the cycle after done.
- Abort: op=11, data=1, count=10, abort in the 4th EXEC cycle → exactly 3 writes, no done, busy drops next cycle, result unchanged.
- Rotate: with ALU_SEQ_ROTATE_EN, op=00, count=4 → op_sel 00,01,10,11 across EXEC. Without the macro, op_sel stays 00 for all 4 cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: default widths, FSM state codes,
// datapath op codes and the op rotation helper.
package alu_seq_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef logic [1:0] state_t;
    typedef logic [1:0] op_t;

    // FSM state codes
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_EXEC = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Datapath mux select codes
    localparam op_t OP_NEG_R1  = 2'd0;  // ACC <= -R1
    localparam op_t OP_AND     = 2'd1;  // ACC <= R1 & ACC
    localparam op_t OP_NEG_ACC = 2'd2;  // ACC <= -ACC
    localparam op_t OP_ADD     = 2'd3;  // ACC <= ACC + R1

    // Next op in the legacy free-running order, wrapping 11 -> 00
    function automatic op_t op_next(input op_t op);
        return op + 2'd1;
    endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// Remaining-write down-counter for the ALU sequencer.
// Optional macro ALU_SEQ_ROTATE_EN: the op select advances by one on every
// write cycle instead of staying at the latched op.
module alu_seq_cnt
    import alu_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_dec,
    input  op_t              i_op,
    output logic             o_last,
    output op_t              o_op
);

    logic [CNT_W-1:0] r_rem;

    // Remaining write count: loaded before EXEC, decremented per write cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_count;
        end else if (i_dec && (r_rem != '0)) begin
            r_rem <= r_rem - CNT_W'(1);
        end
    end

    assign o_last = (r_rem == CNT_W'(1));

`ifdef ALU_SEQ_ROTATE_EN
    op_t r_op;

    // Rotating op select: starts at the latched op, steps once per write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op <= OP_NEG_R1;
        end else if (i_load) begin
            r_op <= i_op;
        end else if (i_dec) begin
            r_op <= op_next(r_op);
        end
    end

    assign o_op = r_op;
`else
    assign o_op = i_op;
`endif

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command-driven sequencer for the R1/ACC ALU datapath. Accepts one command
// (op, operand, repeat count), loads R1, strobes ACC writes `count` times and
// returns the final ACC with a one-cycle done pulse.
// Optional macro ALU_SEQ_ROTATE_EN: op select rotates across write cycles.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              abort,
    input  logic [DATA_W-1:0] acc_q,
    output logic              r1_load,
    output logic [DATA_W-1:0] r1_data,
    output logic [1:0]        op_sel,
    output logic              acc_we,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_t            r_state;
    state_t            w_state_next;
    op_t               r_op;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_result;

    logic              w_accept;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_last;
    op_t               w_exec_op;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    assign w_cnt_load = (r_state == ST_LOAD);
    // Abort suppresses the write in its own cycle, so the counter must not move
    assign w_cnt_dec  = (r_state == ST_EXEC) && !abort;

    alu_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_cnt_load),
        .i_count (r_count),
        .i_dec   (w_cnt_dec),
        .i_op    (r_op),
        .o_last  (w_last),
        .o_op    (w_exec_op)
    );

    // Next-state decode; abort takes priority over finishing EXEC
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_LOAD;
            ST_LOAD: begin
                if (abort)                 w_state_next = ST_IDLE;
                else if (r_count == '0)    w_state_next = ST_DONE;
                else                       w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (abort)       w_state_next = ST_IDLE;
                else if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_NEG_R1;
            r_data  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_op    <= cmd_op;
            r_data  <= cmd_data;
            r_count <= cmd_count;
        end
    end

    // Result snapshot taken in DONE; aborted commands leave it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (r_state == ST_DONE) begin
            r_result <= acc_q;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign r1_load   = (r_state == ST_LOAD);
    assign r1_data   = r_data;
    assign acc_we    = (r_state == ST_EXEC) && !abort;
    assign op_sel    = (r_state == ST_EXEC) ? w_exec_op : r_op;
    assign done      = (r_state == ST_DONE);
    // Bypass so result is already valid in the done cycle itself
    assign result    = (r_state == ST_DONE) ? acc_q : r_result;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with a behavioural R1/ACC datapath.
// Expected values are hand-computed; build with ALU_SEQ_ROTATE_EN to check
// the rotating op select.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [7:0]  cmd_count;
    logic        abort;
    logic [31:0] acc_q;
    logic        r1_load;
    logic [31:0] r1_data;
    logic [1:0]  op_sel;
    logic        acc_we;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_err;

    // Datapath model
    logic [31:0] dp_r1;
    logic [31:0] dp_acc;
    logic        dp_preset;
    logic [31:0] dp_preset_val;

    // Per-command observations
    int          n_wr;
    int          n_ld;
    int          done_cyc;
    int          stop_cyc;
    logic [31:0] res;
    logic [1:0]  ops [0:15];

    alu_seq_ctrl #(
        .DATA_W (32),
        .CNT_W  (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .abort     (abort),
        .acc_q     (acc_q),
        .r1_load   (r1_load),
        .r1_data   (r1_data),
        .op_sel    (op_sel),
        .acc_we    (acc_we),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        dp_r1  = 32'd0;
        dp_acc = 32'd0;
    end

    // R1/ACC datapath driven by the controller strobes
    always @(posedge clk) begin
        if (dp_preset) begin
            dp_acc <= dp_preset_val;
        end else if (acc_we) begin
            case (op_sel)
                2'd0:    dp_acc <= -dp_r1;
                2'd1:    dp_acc <= dp_r1 & dp_acc;
                2'd2:    dp_acc <= -dp_acc;
                default: dp_acc <= dp_acc + dp_r1;
            endcase
        end
        if (r1_load) dp_r1 <= r1_data;
    end

    assign acc_q = dp_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Force ACC to a value over one clock edge (controller must be idle)
    task automatic preset_acc(input logic [31:0] val);
        @(negedge clk);
        dp_preset     = 1'b1;
        dp_preset_val = val;
        @(negedge clk);
        dp_preset     = 1'b0;
    endtask

    // Present a command in the current cycle (cycle 0) and run until done or
    // return to idle; abort is raised in cycle abort_at (0 = never).
    // Returns sampled #1 after the negedge of the final cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] data,
                         input logic [7:0] cnt, input int abort_at);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt;
        abort     = 1'b0;
        #1;
        check_eq("accept_ready", {31'd0, cmd_ready}, 32'd1);
        n_wr     = 0;
        n_ld     = 0;
        done_cyc = 0;
        stop_cyc = 0;
        res      = 32'hx;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            abort     = (k == abort_at);
            #1;
            if (acc_we) begin
                if (n_wr < 16) ops[n_wr] = op_sel;
                n_wr++;
            end
            if (r1_load) n_ld++;
            if (done) begin
                done_cyc = k;
                res      = result;
            end else if (!busy) begin
                stop_cyc = k;
            end
            if (done || !busy) begin
                abort = 1'b0;
                break;
            end
        end
        if (done_cyc == 0 && stop_cyc == 0) check_eq("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_op        = 2'd0;
        cmd_data      = 32'd0;
        cmd_count     = 8'd0;
        abort         = 1'b0;
        dp_preset     = 1'b0;
        dp_preset_val = 32'd0;

        // Reset state
        #1;
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_opsel", {30'd0, op_sel}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add: ACC=5, R1=7, 3 writes -> 26, done at cycle 5
        preset_acc(32'd5);
        issue(2'd3, 32'd7, 8'd3, 0);
        check_eq("add_r1_loads", n_ld, 32'd1);
        check_eq("add_writes", n_wr, 32'd3);
        check_eq("add_done_cyc", done_cyc, 32'd5);
        check_eq("add_result", res, 32'd26);
        @(negedge clk);
        #1;
        check_eq("add_done_pulse", {31'd0, done}, 32'd0);
        check_eq("add_result_hold", result, 32'd26);
        check_eq("idle_opsel_held", {30'd0, op_sel}, 32'd3);

        // Zero count: R1 loaded once, no writes, done at cycle 2
        issue(2'd1, 32'hFFFF_0000, 8'd0, 0);
        check_eq("zero_r1_loads", n_ld, 32'd1);
        check_eq("zero_writes", n_wr, 32'd0);
        check_eq("zero_done_cyc", done_cyc, 32'd2);
        check_eq("zero_result", res, 32'd26);
        @(negedge clk);

        // Negate with wrap, then a back-to-back command held valid
        preset_acc(32'h8000_0000);
        issue(2'd2, 32'd0, 8'd1, 0);
        check_eq("neg_done_cyc", done_cyc, 32'd3);
        check_eq("neg_result", res, 32'h8000_0000);
        check_eq("b2b_ready_in_done", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_data  = 32'd2;
        cmd_count = 8'd2;
        @(negedge clk);
        #1;
        check_eq("b2b_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("b2b_idle_done", {31'd0, done}, 32'd0);
        issue(2'd3, 32'd2, 8'd2, 0);
        check_eq("b2b_r1_loads", n_ld, 32'd1);
        check_eq("b2b_done_cyc", done_cyc, 32'd4);
        check_eq("b2b_result", res, 32'h8000_0004);
        @(negedge clk);

        // Abort in the 4th EXEC cycle (cycle 5): 3 writes, no done
        preset_acc(32'd100);
        issue(2'd3, 32'd1, 8'd10, 5);
        check_eq("abort_writes", n_wr, 32'd3);
        check_eq("abort_no_done", done_cyc, 32'd0);
        check_eq("abort_idle_cyc", stop_cyc, 32'd6);
        check_eq("abort_acc", acc_q, 32'd103);
        check_eq("abort_result", result, 32'h8000_0004);
        @(negedge clk);

        // Op select across EXEC: rotating or constant
        preset_acc(32'd0);
        issue(2'd0, 32'd3, 8'd4, 0);
        check_eq("rot_writes", n_wr, 32'd4);
`ifdef ALU_SEQ_ROTATE_EN
        check_eq("rot_op0", {30'd0, ops[0]}, 32'd0);
        check_eq("rot_op1", {30'd0, ops[1]}, 32'd1);
        check_eq("rot_op2", {30'd0, ops[2]}, 32'd2);
        check_eq("rot_op3", {30'd0, ops[3]}, 32'd3);
        check_eq("rot_result", res, 32'd2);
`else
        check_eq("rot_op0", {30'd0, ops[0]}, 32'd0);
        check_eq("rot_op1", {30'd0, ops[1]}, 32'd0);
        check_eq("rot_op2", {30'd0, ops[2]}, 32'd0);
        check_eq("rot_op3", {30'd0, ops[3]}, 32'd0);
        check_eq("rot_result", res, 32'hFFFF_FFFD);
`endif
        @(negedge clk);

        // Reset asserted mid-EXEC: outputs return to reset values at once
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_data  = 32'h1234_5678;
        cmd_count = 8'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("pre_rst_acc_we", {31'd0, acc_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_acc_we", {31'd0, acc_we}, 32'd0);
        check_eq("mid_rst_r1_load", {31'd0, r1_load}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_opsel", {30'd0, op_sel}, 32'd0);
        check_eq("mid_rst_r1_data", r1_data, 32'd0);
        check_eq("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
